mem_req_demux: RTL and testbench
================================

# mem_req_demux

Routes one CPU data-memory request stream to one of two targets: data RAM (target 0) or the MMIO peripheral bus (target 1). The target is chosen from the request address. Each target's response is returned to the MEM stage on a single response channel. The block sits between the MEM stage and the memory/peripheral side, and it is the distributing counterpart of the pipeline's 2:1 selectors. It allows one outstanding transaction at a time and has a timeout that returns an error response.

## Interface
Parameters:
- MMIO_BASE, 32'hFFFF_0000, first address routed to target 1
- MMIO_SIZE, 32'h0001_0000, size of the MMIO window in bytes
- TIMEOUT, 8'd255, number of cycles in ISSUE+WAIT before an error response

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset; synchronous, active-low
- req_valid / req_ready  in / out  1 / 1  CPU request handshake
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_be  in  4  byte enables
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  timeout flag; valid only when resp_valid = 1
- resp_rdata  out  32  read data; 0 for writes and errors
- t0_valid, t1_valid  out  1  request to target 0 / target 1
- t0_ready, t1_ready  in  1  target accepts the request
- t_we, t_addr, t_wdata, t_be  out  1/32/32/4  shared, latched request fields
- t0_resp_valid, t1_resp_valid  in  1  target response pulse
- t0_rdata, t1_rdata  in  32  target read data

## Operation
- Target select: sel = 1 iff MMIO_BASE <= addr < MMIO_BASE+MMIO_SIZE. The range check uses 33-bit unsigned arithmetic so a window ending at 2^32 does not wrap. All other addresses select target 0.
- FSM states:
  - IDLE: req_ready = 1. On req_valid & req_ready, latch we/addr/wdata/be and sel, clear the timer, go to ISSUE.
  - ISSUE: assert t{sel}_valid; the other target's valid stays 0. On t{sel}_ready, go to WAIT.
  - WAIT: on t{sel}_resp_valid, register rdata (forced to 0 if we = 1), pulse resp_valid, go to IDLE.
  - Timeout: in ISSUE or WAIT, when the timer reaches TIMEOUT, pulse resp_valid with resp_err = 1 and rdata = 0, deassert t_valid, go to IDLE.
- Target responses arriving in IDLE or ISSUE, or from the non-selected target, are ignored.
- If a response and the timeout occur in the same cycle, the response wins: resp_err = 0.
- t_* fields are stable from ISSUE entry until return to IDLE.

## Timing
- Reset: when rst_n = 0 at a posedge, the next state is IDLE and timer = 0.
- Output values after reset: resp_valid = 0, resp_err = 0, resp_rdata = 0, t0_valid = t1_valid = 0, t_* = 0, req_ready = 1.
- Reset mid-transaction: the transaction is abandoned with no response. A late target response is dropped.
- Latency: request accepted at edge N. t_valid is high in cycle N+1. If ready in N+1, the block is in WAIT from N+2. A target response at edge M gives resp_valid high in cycle M+1. Minimum is 3 cycles from accept to response.
- resp_valid is always exactly 1 cycle. req_ready is low from the accept edge until the cycle after the resp_valid edge. The next request can be accepted in the cycle after resp_valid.
- Timer increments every cycle in ISSUE and WAIT. It saturates, never wraps.

## Structure
- Shared package (mem_bus_pkg): FSM state enum (IDLE, ISSUE, WAIT), default MMIO_BASE/MMIO_SIZE constants, and the request-field record (we, addr, wdata, be).
- Sub-module addr_decode: combinational range check producing sel. It is reused by the instruction-side fetch path.
- All other logic (FSM, latch, timer, response register) stays in mem_req_demux.

## Test plan
- Read RAM: addr 0x0000_1000, t0 ready immediately, t0_resp with 0xCAFEBABE 2 cycles later. Expect t1_valid never high, resp_rdata = 0xCAFEBABE, resp_err = 0, 1-cycle pulse.
- Write MMIO: addr 0xFFFF_0004, be = 4'b0011, wdata 0x1234_5678. Expect t1_valid, t_be = 0011, t_wdata correct; on t1_resp, resp_rdata = 0.
- Boundaries: addr 0xFFFE_FFFF goes to t0; 0xFFFF_0000 and 0xFFFF_FFFF go to t1. With MMIO_BASE = 0, MMIO_SIZE = 0, everything goes to t0.
- Timeout: t0_ready held 0 with TIMEOUT = 8. Expect resp_valid with resp_err = 1, rdata = 0, and t0_valid low after the pulse.
- Stray responses: t1_resp_valid during a t0 transaction, and t0_resp_valid in IDLE. Expect no resp_valid and no state change.
- Reset in WAIT: rst_n low one cycle, then t0_resp arrives. Expect no resp_valid, req_ready = 1, and a fresh request served normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory request path: FSM states,
// default MMIO window and the latched request record.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] DEF_MMIO_SIZE = 32'h0001_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

endpackage

// File: rtl/addr_decode.sv
// Address window check: sel = 1 when BASE <= addr < BASE + SIZE.
// Evaluated in 33 bits so a window ending exactly at 2^32 does not wrap.
module addr_decode
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] BASE = DEF_MMIO_BASE,
  parameter logic [31:0] SIZE = DEF_MMIO_SIZE
) (
  input  logic [31:0] addr,
  output logic        sel
);

  logic [32:0] addr_x;
  logic [32:0] lo;
  logic [32:0] hi;

  assign addr_x = {1'b0, addr};
  assign lo     = {1'b0, BASE};
  assign hi     = {1'b0, BASE} + {1'b0, SIZE};
  assign sel    = (addr_x >= lo) && (addr_x < hi);

endmodule

// File: rtl/mem_req_demux.sv
// Routes the MEM-stage request stream to data RAM (t0) or MMIO (t1),
// one outstanding transaction, with an error response on timeout.
//
//   state | meaning
//   IDLE  | ready for a new request; req_ready = 1
//   ISSUE | request presented on t{sel}_valid, waiting for t{sel}_ready
//   WAIT  | request taken, waiting for t{sel}_resp_valid
module mem_req_demux
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter logic [31:0] MMIO_SIZE = DEF_MMIO_SIZE,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        t0_valid,
  output logic        t1_valid,
  input  logic        t0_ready,
  input  logic        t1_ready,
  output logic        t_we,
  output logic [31:0] t_addr,
  output logic [31:0] t_wdata,
  output logic [3:0]  t_be,
  input  logic        t0_resp_valid,
  input  logic        t1_resp_valid,
  input  logic [31:0] t0_rdata,
  input  logic [31:0] t1_rdata
);

  state_t      state;
  mem_req_t    req_q;
  logic        sel_dec;
  logic        sel_q;
  logic [7:0]  timer;
  logic        tgt_ready;
  logic        tgt_resp;
  logic [31:0] tgt_rdata;
  logic        timer_done;

  addr_decode #(
    .BASE (MMIO_BASE),
    .SIZE (MMIO_SIZE)
  ) u_addr_decode (
    .addr (req_addr),
    .sel  (sel_dec)
  );

  // Only the selected target's handshake and response are ever looked at,
  // which is what makes stray responses from the other target harmless.
  assign tgt_ready  = sel_q ? t1_ready      : t0_ready;
  assign tgt_resp   = sel_q ? t1_resp_valid : t0_resp_valid;
  assign tgt_rdata  = sel_q ? t1_rdata      : t0_rdata;
  assign timer_done = (timer == TIMEOUT);

  assign t_we    = req_q.we;
  assign t_addr  = req_q.addr;
  assign t_wdata = req_q.wdata;
  assign t_be    = req_q.be;

  // Request FSM with latched request, timeout timer and response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      sel_q      <= 1'b0;
      timer      <= 8'd0;
      req_ready  <= 1'b1;
      t0_valid   <= 1'b0;
      t1_valid   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q     <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
            sel_q     <= sel_dec;
            timer     <= 8'd0;
            t0_valid  <= ~sel_dec;
            t1_valid  <= sel_dec;
            req_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          // A response in the same cycle as the timeout takes priority.
          if ((state == WAIT) && tgt_resp) begin
            resp_valid <= 1'b1;
            resp_rdata <= req_q.we ? 32'd0 : tgt_rdata;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else if (timer_done) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            t0_valid   <= 1'b0;
            t1_valid   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            if (timer != 8'hFF) begin
              timer <= timer + 8'd1;
            end
            if ((state == ISSUE) && tgt_ready) begin
              t0_valid <= 1'b0;
              t1_valid <= 1'b0;
              state    <= WAIT;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_demux.sv
// Directed bench for mem_req_demux: main instance with TIMEOUT = 8 and the
// default MMIO window, second instance with an empty window (base 0, size 0).
module tb_mem_req_demux;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        t0_valid;
  logic        t1_valid;
  logic        t0_ready;
  logic        t1_ready;
  logic        t_we;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_be;
  logic        t0_resp_valid;
  logic        t1_resp_valid;
  logic [31:0] t0_rdata;
  logic [31:0] t1_rdata;

  logic        b_req_valid;
  logic        b_req_ready;
  logic        b_resp_valid;
  logic        b_resp_err;
  logic [31:0] b_resp_rdata;
  logic        b_t0_valid;
  logic        b_t1_valid;
  logic        b_t0_ready;
  logic        b_t1_ready;
  logic        b_t_we;
  logic [31:0] b_t_addr;
  logic [31:0] b_t_wdata;
  logic [3:0]  b_t_be;
  logic        b_t0_resp_valid;
  logic        b_t1_resp_valid;

  int total = 0;
  int bad   = 0;

  mem_req_demux #(
    .MMIO_BASE (32'hFFFF_0000),
    .MMIO_SIZE (32'h0001_0000),
    .TIMEOUT   (8'd8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .t0_valid      (t0_valid),
    .t1_valid      (t1_valid),
    .t0_ready      (t0_ready),
    .t1_ready      (t1_ready),
    .t_we          (t_we),
    .t_addr        (t_addr),
    .t_wdata       (t_wdata),
    .t_be          (t_be),
    .t0_resp_valid (t0_resp_valid),
    .t1_resp_valid (t1_resp_valid),
    .t0_rdata      (t0_rdata),
    .t1_rdata      (t1_rdata)
  );

  mem_req_demux #(
    .MMIO_BASE (32'h0000_0000),
    .MMIO_SIZE (32'h0000_0000),
    .TIMEOUT   (8'd255)
  ) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (b_req_valid),
    .req_ready     (b_req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .resp_valid    (b_resp_valid),
    .resp_err      (b_resp_err),
    .resp_rdata    (b_resp_rdata),
    .t0_valid      (b_t0_valid),
    .t1_valid      (b_t1_valid),
    .t0_ready      (b_t0_ready),
    .t1_ready      (b_t1_ready),
    .t_we          (b_t_we),
    .t_addr        (b_t_addr),
    .t_wdata       (b_t_wdata),
    .t_be          (b_t_be),
    .t0_resp_valid (b_t0_resp_valid),
    .t1_resp_valid (b_t1_resp_valid),
    .t0_rdata      (t0_rdata),
    .t1_rdata      (t1_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full transaction on the main instance; response arrives resp_delay
  // cycles after the first WAIT cycle.
  task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input logic tsel,
                         input logic [31:0] rd, input int resp_delay);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".t0v"}, t0_valid, !tsel);
    check({tag, ".t1v"}, t1_valid, tsel);
    check({tag, ".rdy_lo"}, req_ready, 1'b0);
    check({tag, ".t_we"}, t_we, we);
    check({tag, ".t_addr"}, t_addr, addr);
    check({tag, ".t_wdata"}, t_wdata, wdata);
    check({tag, ".t_be"}, t_be, be);
    if (tsel) t1_ready = 1'b1; else t0_ready = 1'b1;
    @(negedge clk);
    t0_ready = 1'b0; t1_ready = 1'b0;
    check({tag, ".tv_wait"}, {t0_valid, t1_valid}, 2'b00);
    check({tag, ".t_addr_wait"}, t_addr, addr);
    repeat (resp_delay) @(negedge clk);
    if (tsel) begin t1_resp_valid = 1'b1; t1_rdata = rd; end
    else      begin t0_resp_valid = 1'b1; t0_rdata = rd; end
    @(negedge clk);
    t0_resp_valid = 1'b0; t1_resp_valid = 1'b0;
    check({tag, ".resp_v"}, resp_valid, 1'b1);
    check({tag, ".resp_err"}, resp_err, 1'b0);
    check({tag, ".rdata"}, resp_rdata, we ? 32'd0 : rd);
    check({tag, ".rdy_hi"}, req_ready, 1'b1);
    @(negedge clk);
    check({tag, ".resp_pulse"}, resp_valid, 1'b0);
  endtask

  // Single transaction on the empty-window instance; must always go to t0.
  task automatic run_b(input string tag, input logic [31:0] addr);
    @(negedge clk);
    b_req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = 32'd0; req_be = 4'hF;
    @(negedge clk);
    b_req_valid = 1'b0;
    check({tag, ".t0v"}, b_t0_valid, 1'b1);
    check({tag, ".t1v"}, b_t1_valid, 1'b0);
    b_t0_ready = 1'b1;
    @(negedge clk);
    b_t0_ready = 1'b0;
    b_t0_resp_valid = 1'b1;
    @(negedge clk);
    b_t0_resp_valid = 1'b0;
    check({tag, ".resp_v"}, b_resp_valid, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    t0_ready = 1'b0; t1_ready = 1'b0;
    t0_resp_valid = 1'b0; t1_resp_valid = 1'b0;
    t0_rdata = 32'd0; t1_rdata = 32'd0;
    b_req_valid = 1'b0; b_t0_ready = 1'b0; b_t1_ready = 1'b0;
    b_t0_resp_valid = 1'b0; b_t1_resp_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.resp_v", resp_valid, 1'b0);
    check("rst.resp_err", resp_err, 1'b0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.tv", {t0_valid, t1_valid}, 2'b00);
    check("rst.t_addr", t_addr, 32'd0);
    check("rst.t_wdata", t_wdata, 32'd0);
    check("rst.t_be_we", {t_we, t_be}, 5'd0);
    check("rst.ready", req_ready, 1'b1);
    rst_n = 1'b1;

    run_txn("rd_ram", 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b0, 32'hCAFE_BABE, 1);
    run_txn("wr_mmio", 1'b1, 32'hFFFF_0004, 32'h1234_5678, 4'b0011, 1'b1, 32'hDEAD_BEEF, 0);
    run_txn("bnd_below", 1'b0, 32'hFFFE_FFFF, 32'h0, 4'hF, 1'b0, 32'h0000_0011, 0);
    run_txn("bnd_base", 1'b0, 32'hFFFF_0000, 32'h0, 4'hF, 1'b1, 32'h0000_0022, 0);
    run_txn("bnd_top", 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h1, 1'b1, 32'h0000_0033, 2);

    // Response lands in the same cycle the timer reaches TIMEOUT.
    run_txn("resp_wins", 1'b0, 32'h0000_2000, 32'h0, 4'hF, 1'b0, 32'h5555_AAAA, 7);

    // Timeout: t0 never ready; accept edge N, error pulse in cycle N+10.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_3000; req_be = 4'hF;
    t0_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("to.before_v", resp_valid, 1'b0);
    check("to.before_t0v", t0_valid, 1'b1);
    @(negedge clk);
    check("to.resp_v", resp_valid, 1'b1);
    check("to.resp_err", resp_err, 1'b1);
    check("to.rdata", resp_rdata, 32'd0);
    check("to.t0v", t0_valid, 1'b0);
    check("to.ready", req_ready, 1'b1);
    @(negedge clk);
    check("to.pulse", resp_valid, 1'b0);
    check("to.t0v_after", t0_valid, 1'b0);

    // Stray responses: t0 response during ISSUE, t1 response during a t0 WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4000; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    t0_resp_valid = 1'b1; t0_rdata = 32'hBAD0_0001;
    @(negedge clk);
    t0_resp_valid = 1'b0;
    check("stray.issue_v", resp_valid, 1'b0);
    check("stray.issue_t0v", t0_valid, 1'b1);
    t0_ready = 1'b1;
    @(negedge clk);
    t0_ready = 1'b0;
    t1_resp_valid = 1'b1; t1_rdata = 32'hBAD0_0002;
    @(negedge clk);
    t1_resp_valid = 1'b0;
    check("stray.t1_v", resp_valid, 1'b0);
    check("stray.t1_ready", req_ready, 1'b0);
    t0_resp_valid = 1'b1; t0_rdata = 32'h1122_3344;
    @(negedge clk);
    t0_resp_valid = 1'b0;
    check("stray.real_v", resp_valid, 1'b1);
    check("stray.real_rdata", resp_rdata, 32'h1122_3344);
    @(negedge clk);
    t0_resp_valid = 1'b1; t0_rdata = 32'hBAD0_0003;
    @(negedge clk);
    t0_resp_valid = 1'b0;
    check("stray.idle_v", resp_valid, 1'b0);
    check("stray.idle_ready", req_ready, 1'b1);
    check("stray.idle_tv", {t0_valid, t1_valid}, 2'b00);

    // Reset while in WAIT, then a late t0 response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_5000; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    t0_ready = 1'b1;
    @(negedge clk);
    t0_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstw.ready", req_ready, 1'b1);
    check("rstw.tv", {t0_valid, t1_valid}, 2'b00);
    t0_resp_valid = 1'b1; t0_rdata = 32'hBAD0_0004;
    @(negedge clk);
    t0_resp_valid = 1'b0;
    check("rstw.late_v", resp_valid, 1'b0);
    check("rstw.late_ready", req_ready, 1'b1);
    run_txn("rstw.fresh", 1'b0, 32'h0000_6000, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D, 1);

    // Empty MMIO window: everything goes to t0.
    run_b("empty.base", 32'hFFFF_0000);
    run_b("empty.zero", 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
